sample_mem_arbiter: RTL and testbench

//  Shares the single memory command port between the capture write path (sample packets + addresses)
//  and the readback path (read requests). Buffers capture writes in a small FIFO, back-pressures capture
//  via pageFull, schedules reads/writes with watermark priority, and tracks one outstanding read.

---
 rtl/sample_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sample_mem_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_mem_arbiter.sv
// sample_mem_arbiter: shares one memory command port between buffered capture writes and readback reads.
// Latency: one IDLE decision cycle, then the command is presented and held; at least 2 cycles per command.
// Backpressure: pageFull at FIFO level >= AF_LEVEL; mem_cmd_* held stable while mem_cmd_ready is low.
// Optional feature macro: ARB_STATS_EN adds accepted-command and stall-cycle counters.

module sample_mem_arbiter_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] headData,
    output logic [AW:0]      level,
    output logic [AW:0]      levelNext,
    output logic             full,
    output logic             empty
);
    localparam logic [AW:0]   DEPTH   = (AW+1)'(1 << AW);
    localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = (AW)'(1);

    logic [WIDTH-1:0] mem [1 << AW];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;

    assign headData = mem[rdPtr];
    assign full     = (level == DEPTH);
    assign empty    = (level == '0);

    // Occupancy after this cycle's push/pop; the caller only pushes into a full FIFO when it also pops.
    always_comb begin
        levelNext = level;
        case ({push, pop})
            2'b10:   levelNext = level + LVL_ONE;
            2'b01:   levelNext = level - LVL_ONE;
            default: levelNext = level;
        endcase
    end

    // Storage has no reset; only entries below the level are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointer and level bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            level <= levelNext;
        end
    end
endmodule

module sample_mem_arbiter #(
    parameter int SAMPLE_PACKET_WIDTH = 32,
    parameter int FIFO_AW             = 4,
    parameter int HI_WM               = 12,
    parameter int AF_LEVEL            = 14
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [SAMPLE_PACKET_WIDTH-1:0] wr_data,
    input  logic [26:0]                    wr_addr,
    output logic                           pageFull,
    output logic                           wr_overflow,
    input  logic                           read_req,
    input  logic [26:0]                    read_addr,
    output logic                           read_allowed,
    output logic                           mem_cmd_valid,
    input  logic                           mem_cmd_ready,
    output logic                           mem_cmd_write,
    output logic [26:0]                    mem_cmd_addr,
    output logic [SAMPLE_PACKET_WIDTH-1:0] mem_cmd_wdata,
    input  logic                           mem_rd_valid,
`ifdef ARB_STATS_EN
    output logic [31:0]                    stat_wr_cmds,
    output logic [31:0]                    stat_rd_cmds,
    output logic [31:0]                    stat_stall_cycles,
`endif
    output logic [FIFO_AW:0]               fifo_level
);
    localparam logic [FIFO_AW:0] HI_WM_LVL = (FIFO_AW+1)'(HI_WM);
    localparam logic [FIFO_AW:0] AF_LVL    = (FIFO_AW+1)'(AF_LEVEL);

    typedef struct packed {
        logic [26:0]                    addr;
        logic [SAMPLE_PACKET_WIDTH-1:0] data;
    } wrEntry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_CMD = 2'd1,
        RD_CMD = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    state_t          state;
    grant_t          lastGrant;
    logic            rdOutstanding;

    wrEntry_t        fifoIn;
    wrEntry_t        fifoHead;
    logic [FIFO_AW:0] fifoLevelNext;
    logic            fifoFull;
    logic            fifoEmpty;
    logic            fifoPush;
    logic            fifoPop;

    logic            cmdAccept;
    logic            wrPend;
    logic            rdPend;
    logic            aboveHiWm;
    logic            goWrite;
    logic            goRead;

    assign cmdAccept = mem_cmd_valid & mem_cmd_ready;
    assign fifoPop   = cmdAccept & (state == WR_CMD);
    // A full FIFO still takes a packet when the head leaves in the same cycle.
    assign fifoPush  = wr_en & (~fifoFull | fifoPop);

    assign fifoIn.addr = wr_addr;
    assign fifoIn.data = wr_data;

    sample_mem_arbiter_fifo #(
        .WIDTH ($bits(wrEntry_t)),
        .AW    (FIFO_AW)
    ) u_wrFifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifoPush),
        .pop       (fifoPop),
        .pushData  (fifoIn),
        .headData  (fifoHead),
        .level     (fifo_level),
        .levelNext (fifoLevelNext),
        .full      (fifoFull),
        .empty     (fifoEmpty)
    );

    // Arbitration: high watermark forces writes, a tie goes to whichever side did not win last.
    always_comb begin
        wrPend    = ~fifoEmpty;
        rdPend    = read_req & ~rdOutstanding;
        aboveHiWm = (fifo_level >= HI_WM_LVL);
        goWrite   = wrPend & (aboveHiWm | ~rdPend | (lastGrant == GRANT_READ));
        goRead    = rdPend & ~goWrite;
    end

    // pageFull tracks the post-update level so capture sees it in the same cycle as fifo_level.
    always_ff @(posedge clk) begin
        if (reset) begin
            pageFull <= 1'b0;
        end else begin
            pageFull <= (fifoLevelNext >= AF_LVL);
        end
    end

    // Sticky drop flag: a packet arrived with nowhere to go.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_overflow <= 1'b0;
        end else if (wr_en & fifoFull & ~fifoPop) begin
            wr_overflow <= 1'b1;
        end
    end

    // Command FSM: fields are latched on entry to a command state and held until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            lastGrant     <= GRANT_READ;
            rdOutstanding <= 1'b0;
            read_allowed  <= 1'b0;
            mem_cmd_valid <= 1'b0;
            mem_cmd_write <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_cmd_wdata <= '0;
        end else begin
            read_allowed <= 1'b0;
            if (mem_rd_valid) begin
                rdOutstanding <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (goWrite) begin
                        state         <= WR_CMD;
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_write <= 1'b1;
                        mem_cmd_addr  <= fifoHead.addr;
                        mem_cmd_wdata <= fifoHead.data;
                    end else if (goRead) begin
                        state         <= RD_CMD;
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_write <= 1'b0;
                        mem_cmd_addr  <= read_addr;
                    end
                end
                WR_CMD: begin
                    if (mem_cmd_ready) begin
                        state         <= IDLE;
                        mem_cmd_valid <= 1'b0;
                        lastGrant     <= GRANT_WRITE;
                    end
                end
                RD_CMD: begin
                    if (mem_cmd_ready) begin
                        state         <= IDLE;
                        mem_cmd_valid <= 1'b0;
                        lastGrant     <= GRANT_READ;
                        read_allowed  <= 1'b1;
                        // Acceptance wins over a coinciding completion of the previous read.
                        rdOutstanding <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    // Saturating counters of accepted writes, accepted reads and stalled command cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_wr_cmds      <= '0;
            stat_rd_cmds      <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (cmdAccept & mem_cmd_write & (stat_wr_cmds != '1)) begin
                stat_wr_cmds <= stat_wr_cmds + 32'd1;
            end
            if (cmdAccept & ~mem_cmd_write & (stat_rd_cmds != '1)) begin
                stat_rd_cmds <= stat_rd_cmds + 32'd1;
            end
            if (mem_cmd_valid & ~mem_cmd_ready & (stat_stall_cycles != '1)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_sample_mem_arbiter.sv
`timescale 1ns/1ps
module tb_sample_mem_arbiter;
    localparam int W     = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [26:0] wr_addr;
    logic        pageFull;
    logic        wr_overflow;
    logic        read_req;
    logic [26:0] read_addr;
    logic        read_allowed;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_write;
    logic [26:0] mem_cmd_addr;
    logic [31:0] mem_cmd_wdata;
    logic        mem_rd_valid;
    logic [AW:0] fifo_level;
`ifdef ARB_STATS_EN
    logic [31:0] stat_wr_cmds;
    logic [31:0] stat_rd_cmds;
    logic [31:0] stat_stall_cycles;
`endif

    always #5 clk = ~clk;

    sample_mem_arbiter #(
        .SAMPLE_PACKET_WIDTH (W),
        .FIFO_AW             (AW),
        .HI_WM               (12),
        .AF_LEVEL            (AF)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .wr_en             (wr_en),
        .wr_data           (wr_data),
        .wr_addr           (wr_addr),
        .pageFull          (pageFull),
        .wr_overflow       (wr_overflow),
        .read_req          (read_req),
        .read_addr         (read_addr),
        .read_allowed      (read_allowed),
        .mem_cmd_valid     (mem_cmd_valid),
        .mem_cmd_ready     (mem_cmd_ready),
        .mem_cmd_write     (mem_cmd_write),
        .mem_cmd_addr      (mem_cmd_addr),
        .mem_cmd_wdata     (mem_cmd_wdata),
        .mem_rd_valid      (mem_rd_valid),
`ifdef ARB_STATS_EN
        .stat_wr_cmds      (stat_wr_cmds),
        .stat_rd_cmds      (stat_rd_cmds),
        .stat_stall_cycles (stat_stall_cycles),
`endif
        .fifo_level        (fifo_level)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: queue of buffered packets plus a few flags.
    typedef struct { logic [26:0] addr; logic [31:0] data; } wr_t;
    wr_t         q[$];
    bit          expOvf;
    bit          modelRdOut;
    logic [26:0] expRdAddr;
    int          wrCount;
    int          rdCount;
    int          stallCount;
    bit          grantLog[$];   // 1 = write, 0 = read

    typedef struct { bit wr; int expLevel; bit expPf; bit expOvf; bit expValid; } vec_t;
    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // One clock: predict effect of current inputs, advance, compare.
    task automatic cycle();
        bit          acc;
        bit          rdAcc;
        bit          holdNow;
        logic        hWrite;
        logic [26:0] hAddr;
        logic [31:0] hData;
        wr_t         e;
        acc   = (mem_cmd_valid === 1'b1) && (mem_cmd_ready === 1'b1);
        rdAcc = 1'b0;
        if (!reset && acc) begin
            if (mem_cmd_write) begin
                if (q.size() == 0) begin
                    check("write_with_empty_fifo", 1, 0);
                end else begin
                    check("wr_addr_order", mem_cmd_addr, q[0].addr);
                    check("wr_data_order", mem_cmd_wdata, q[0].data);
                    void'(q.pop_front());
                end
                wrCount++;
                grantLog.push_back(1'b1);
            end else begin
                check("read_while_outstanding", modelRdOut, 0);
                check("rd_addr", mem_cmd_addr, expRdAddr);
                rdAcc = 1'b1;
                rdCount++;
                grantLog.push_back(1'b0);
            end
        end
        if (!reset && (mem_cmd_valid === 1'b1) && !mem_cmd_ready) stallCount++;
        if (!reset && wr_en) begin
            if (q.size() < DEPTH) begin
                e.addr = wr_addr;
                e.data = wr_data;
                q.push_back(e);
            end else begin
                expOvf = 1'b1;
            end
        end
        if (!reset) begin
            if (rdAcc) modelRdOut = 1'b1;
            else if (mem_rd_valid) modelRdOut = 1'b0;
        end
        holdNow = !reset && (mem_cmd_valid === 1'b1) && !mem_cmd_ready;
        hWrite  = mem_cmd_write;
        hAddr   = mem_cmd_addr;
        hData   = mem_cmd_wdata;
        if (reset) begin
            q.delete();
            expOvf     = 1'b0;
            modelRdOut = 1'b0;
            rdAcc      = 1'b0;
            wrCount    = 0;
            rdCount    = 0;
            stallCount = 0;
        end
        @(posedge clk);
        #1;
        check("fifo_level", fifo_level, q.size());
        check("pageFull", pageFull, q.size() >= AF);
        check("wr_overflow", wr_overflow, expOvf);
        check("read_allowed", read_allowed, rdAcc);
        if (holdNow) begin
            check("valid_held", mem_cmd_valid, 1);
            check("write_held", mem_cmd_write, hWrite);
            check("addr_held", mem_cmd_addr, hAddr);
            check("wdata_held", mem_cmd_wdata, hData);
        end
        if (reset) check("valid_after_reset", mem_cmd_valid, 0);
    endtask

    task automatic doReset();
        reset         = 1'b1;
        wr_en         = 1'b0;
        read_req      = 1'b0;
        mem_cmd_ready = 1'b0;
        mem_rd_valid  = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        grantLog.delete();
    endtask

    task automatic waitIdle(input int limit);
        int n;
        n = 0;
        while (!(fifo_level == 0 && mem_cmd_valid == 1'b0)) begin
            if (n >= limit) begin
                timeoutFail("wait_idle");
                return;
            end
            cycle();
            n++;
        end
    endtask

    task automatic waitReadAllowed(input int limit);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!read_allowed && n < limit);
        if (!read_allowed) timeoutFail("wait_read_allowed");
    endtask

    task automatic checkLog(input string name, input bit pat[$]);
        if (grantLog.size() < pat.size()) begin
            check({name, "_len"}, grantLog.size(), pat.size());
        end else begin
            for (int i = 0; i < pat.size(); i++) check(name, grantLog[i], pat[i]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit patAlt[$];
        bit patHi[$];
        int nReads;
        wr_data   = '0;
        wr_addr   = '0;
        read_addr = '0;
        expRdAddr = '0;

        // Table: fill to full with memory stalled, then one more packet.
        for (int i = 0; i < 17; i++) begin
            vecs[i].wr       = 1'b1;
            vecs[i].expLevel = (i + 1 > DEPTH) ? DEPTH : i + 1;
            vecs[i].expPf    = (vecs[i].expLevel >= AF);
            vecs[i].expOvf   = (i >= DEPTH);
            vecs[i].expValid = (i >= 1);
        end

        // Reset state.
        doReset();
        check("rst_valid", mem_cmd_valid, 0);
        check("rst_write", mem_cmd_write, 0);
        check("rst_addr", mem_cmd_addr, 0);
        check("rst_wdata", mem_cmd_wdata, 0);
        check("rst_read_allowed", read_allowed, 0);
        check("rst_pageFull", pageFull, 0);
        check("rst_overflow", wr_overflow, 0);
        check("rst_level", fifo_level, 0);

        // Fill with ready=0.
        for (int i = 0; i < 17; i++) begin
            wr_en   = vecs[i].wr;
            wr_addr = 27'(i);
            wr_data = 32'hA000_0000 + i;
            cycle();
            check("tbl_level", fifo_level, vecs[i].expLevel);
            check("tbl_pageFull", pageFull, vecs[i].expPf);
            check("tbl_overflow", wr_overflow, vecs[i].expOvf);
            check("tbl_valid", mem_cmd_valid, vecs[i].expValid);
        end
        wr_en = 1'b0;
        mem_cmd_ready = 1'b1;
        waitIdle(200);
        check("fill_drain_writes", wrCount, 16);
        check("overflow_sticky", wr_overflow, 1);

        // Five writes in order with ready=1.
        doReset();
        mem_cmd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_addr = 27'(i);
            wr_data = 32'h0000_5000 + i;
            cycle();
        end
        wr_en = 1'b0;
        waitIdle(100);
        check("five_writes", wrCount, 5);

        // Single outstanding read.
        doReset();
        mem_cmd_ready = 1'b1;
        read_addr = 27'h123_4567;
        expRdAddr = read_addr;
        read_req  = 1'b1;
        waitReadAllowed(20);
        read_req = 1'b0;
        cycle();
        check("read_allowed_one_pulse", read_allowed, 0);
        check("first_read", rdCount, 1);
        read_addr = 27'h0AB_CDEF;
        expRdAddr = read_addr;
        read_req  = 1'b1;
        repeat (10) cycle();
        check("second_read_blocked", rdCount, 1);
        check("second_read_no_valid", mem_cmd_valid, 0);
        mem_rd_valid = 1'b1;
        cycle();
        mem_rd_valid = 1'b0;
        waitReadAllowed(20);
        read_req = 1'b0;
        check("second_read", rdCount, 2);
        mem_rd_valid = 1'b1;
        cycle();
        mem_rd_valid = 1'b0;
        mem_rd_valid = 1'b1;   // completion with nothing outstanding
        cycle();
        mem_rd_valid = 1'b0;
        cycle();

        // Alternation from reset: first tie goes to the write.
        doReset();
        mem_cmd_ready = 1'b1;
        read_addr = 27'h000_0777;
        expRdAddr = read_addr;
        for (int i = 0; i < 3; i++) begin
            wr_en    = 1'b1;
            wr_addr  = 27'(100 + i);
            wr_data  = 32'hBEEF_0000 + i;
            read_req = (i >= 1);
            cycle();
        end
        wr_en  = 1'b0;
        nReads = 0;
        for (int n = 0; n < 80 && nReads < 3; n++) begin
            cycle();
            mem_rd_valid = read_allowed;
            if (read_allowed) nReads++;
        end
        read_req = 1'b0;
        cycle();
        mem_rd_valid = 1'b0;
        patAlt = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        checkLog("alternate", patAlt);

        // High watermark: writes only until level drops below 12.
        doReset();
        for (int i = 0; i < 13; i++) begin
            wr_en   = 1'b1;
            wr_addr = 27'(200 + i);
            wr_data = 32'hC0DE_0000 + i;
            cycle();
        end
        wr_en = 1'b0;
        read_addr = 27'h000_0ABC;
        expRdAddr = read_addr;
        read_req  = 1'b1;
        mem_cmd_ready = 1'b1;
        waitReadAllowed(60);
        read_req     = 1'b0;
        mem_rd_valid = 1'b1;
        cycle();
        mem_rd_valid = 1'b0;
        patHi = '{1'b1, 1'b1, 1'b0};
        checkLog("hi_watermark", patHi);
        waitIdle(100);

        // Randomized traffic with random ready.
        doReset();
        for (int n = 0; n < 2000; n++) begin
            mem_cmd_ready = ($urandom_range(0, 1) == 1);
            wr_en   = ($urandom_range(0, 2) == 0) && (!pageFull || $urandom_range(0, 3) == 0);
            wr_addr = 27'($urandom);
            wr_data = $urandom;
            if (read_allowed) read_req = 1'b0;
            else if (!read_req && $urandom_range(0, 7) == 0) begin
                read_req  = 1'b1;
                read_addr = 27'($urandom);
                expRdAddr = read_addr;
            end
            if (modelRdOut) mem_rd_valid = ($urandom_range(0, 3) == 0);
            else            mem_rd_valid = ($urandom_range(0, 15) == 0);
            cycle();
        end
        wr_en        = 1'b0;
        read_req     = 1'b0;
        mem_rd_valid = 1'b0;
        mem_cmd_ready = 1'b1;
        waitIdle(200);
`ifdef ARB_STATS_EN
        check("stat_wr_cmds", stat_wr_cmds, wrCount);
        check("stat_rd_cmds", stat_rd_cmds, rdCount);
        check("stat_stall_cycles", stat_stall_cycles, stallCount);
`endif

        // Reset while a command is pending.
        doReset();
        wr_en   = 1'b1;
        wr_addr = 27'h55;
        wr_data = 32'h1234_5678;
        cycle();
        wr_en = 1'b0;
        begin
            int n;
            n = 0;
            while (!mem_cmd_valid && n < 10) begin
                cycle();
                n++;
            end
            if (!mem_cmd_valid) timeoutFail("mid_cmd_valid");
        end
        reset = 1'b1;
        cycle();
        check("mid_reset_valid", mem_cmd_valid, 0);
        check("mid_reset_level", fifo_level, 0);
        reset = 1'b0;
        cycle();
        check("mid_reset_stays_idle", mem_cmd_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
